main_fsm: RTL and testbench
===========================

// Module: main_fsm
// PURPOSE
//  Multi-cycle RISC-V main controller: Moore FSM that sequences Fetch/Decode/Execute/Memory/Writeback.
//  Drives datapath mux selects, write strobes and the 2-bit ALUOp consumed by the ALU decoder.
//  Sits in the controller beside the ALU decoder. Adds a memory-ready wait handshake and illegal-opcode detection.
// PARAMETERS
//  ILLEGAL_TRAP  0  1: unknown opcode parks FSM in S_ERR until reset; 0: unknown opcode returns to S_FETCH
// PORTS
//  clk        in   1  single clock, rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  op         in   7  opcode from instruction register (stable from S_DECODE onward)
//  mem_ready  in   1  unified memory completes access this cycle
//  PCUpdate   out  1  PC write enable (ORed with Branch&Zero outside this block)
//  Branch     out  1  conditional-branch qualifier
//  RegWrite   out  1  register file write enable
//  MemWrite   out  1  data memory write request
//  IRWrite    out  1  instruction register / OldPC load
//  AdrSrc     out  1  memory address: 0=PC, 1=ALUOut
//  ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
//  ALUSrcA    out  2  00=PC, 01=OldPC, 10=rs1 data
//  ALUSrcB    out  2  00=rs2 data, 01=ImmExt, 10=constant 4
//  ALUOp      out  2  00=add, 01=subtract (beq), 10=funct-decoded
//  illegal    out  1  high while in S_ERR (ILLEGAL_TRAP=1); 1-cycle pulse in S_DECODE on unknown op (ILLEGAL_TRAP=0)
// BEHAVIOUR
//  - Reset (reset_n=0, async): state <= S_FETCH. While reset_n=0, all strobes (PCUpdate, IRWrite, RegWrite,
//    MemWrite, Branch, illegal) are forced to 0; selects and ALUOp take their S_FETCH values.
//  - Moore outputs decoded from state only, except IRWrite/PCUpdate in S_FETCH, which are qualified by mem_ready.
//  - Unlisted outputs are 0 in each state.
//  - Recognised opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, jal 1101111, beq 1100011.
//  - States, outputs and transitions:
//    S_FETCH     AdrSrc=0 ALUSrcA=00 ALUSrcB=10 ALUOp=00 ResultSrc=10; IRWrite=PCUpdate=mem_ready.
//                Next state: mem_ready ? S_DECODE : S_FETCH.
//    S_DECODE    ALUSrcA=01 ALUSrcB=01 ALUOp=00. Next state by op:
//                lw,sw->S_MEMADR; R->S_EXECR; I->S_EXECI; jal->S_JAL; beq->S_BEQ;
//                other->S_ERR (TRAP=1) or S_FETCH (TRAP=0).
//    S_MEMADR    ALUSrcA=10 ALUSrcB=01 ALUOp=00. Next state: lw->S_MEMREAD, sw->S_MEMWRITE.
//    S_MEMREAD   AdrSrc=1 ResultSrc=00. Holds until mem_ready=1, then -> S_MEMWB.
//    S_MEMWB     ResultSrc=01 RegWrite=1. Next state: S_FETCH.
//    S_MEMWRITE  AdrSrc=1 ResultSrc=00 MemWrite=1. MemWrite held high every wait cycle;
//                -> S_FETCH on mem_ready=1.
//    S_EXECR     ALUSrcA=10 ALUSrcB=00 ALUOp=10. Next state: S_ALUWB.
//    S_EXECI     ALUSrcA=10 ALUSrcB=01 ALUOp=10. Next state: S_ALUWB.
//    S_JAL       ALUSrcA=01 ALUSrcB=10 ALUOp=00 ResultSrc=00 PCUpdate=1. Next state: S_ALUWB.
//    S_ALUWB     ResultSrc=00 RegWrite=1. Next state: S_FETCH.
//    S_BEQ       ALUSrcA=10 ALUSrcB=00 ALUOp=01 ResultSrc=00 Branch=1. Next state: S_FETCH.
//    S_ERR       illegal=1, all strobes 0. Self-loop; only reset exits.
//  - Cycles per instruction with mem_ready tied high: lw 5, sw 4, R/I 4, jal 4, beq 3.
//    Each mem_ready=0 cycle in S_FETCH, S_MEMREAD or S_MEMWRITE adds one cycle.
//  - An unreachable or invalid state encoding returns to S_FETCH (default branch).
//  - reset_n asserted mid-instruction aborts immediately: no further strobes, and the FSM restarts in S_FETCH.
//  - op is sampled only in S_DECODE and S_MEMADR; op changing in other states has no effect.
// STRUCTURE
//  - Shared package ctrl_pkg holds:
//    - typedef enum logic [3:0] statetype_t (S_FETCH=0 ... S_ERR=11);
//    - opcode localparams: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ;
//    - select constants: ALUOP_ADD/SUB/FUNCT, SRCA_*, SRCB_*, RES_*.
//  - Single module, no sub-modules:
//    - always_ff for the state register;
//    - always_comb for next-state logic;
//    - always_comb for output decode.
// TESTING
//  - Reset mid-S_MEMREAD (reset_n=0 for 1 cycle): state=S_FETCH async; strobes=0 during reset;
//    IRWrite=1 in the first cycle after release with mem_ready=1.
//  - lw, op=0000011, mem_ready=1: state sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB;
//    RegWrite=1 and ResultSrc=01 only in cycle 5.
//  - sw, op=0100011, mem_ready low for 3 cycles in S_MEMWRITE: MemWrite=1 for 4 consecutive cycles, AdrSrc=1,
//    then S_FETCH.
//  - R-type then beq (op=0110011, then 1100011): ALUOp=10 in S_EXECR; ALUOp=01 and Branch=1 in S_BEQ, 3-cycle beq.
//  - jal, op=1101111: S_JAL has PCUpdate=1, ALUSrcA=01, ALUSrcB=10; S_ALUWB follows with RegWrite=1.
//  - Illegal op=1111111: TRAP=1 -> S_ERR, illegal stuck at 1 across 10 cycles, no strobes;
//    TRAP=0 -> 1-cycle illegal pulse, then back to S_FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared controller definitions: FSM state encoding, RISC-V opcodes and datapath select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_ERR      = 4'd11
    } statetype_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_fsm.sv
// Multi-cycle RISC-V main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with a memory-ready wait handshake and illegal-opcode detection.
module main_fsm
    import ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal
);

    statetype_t r_state;
    statetype_t w_next_state;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = ILLEGAL_TRAP ? S_ERR : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    w_next_state = S_MEMREAD;
                end else if (op == OP_SW) begin
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_ERR:      w_next_state = S_ERR;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_illegal   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle, but only committed once memory delivers
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                w_illegal = !ILLEGAL_TRAP && !is_known_op(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = RES_READDATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                ALUOp    = ALUOP_SUB;
                w_branch = 1'b1;
            end
            S_ERR: begin
                w_illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Strobes are masked while reset is low so nothing fires during the async reset window
    assign PCUpdate = w_pc_update & reset_n;
    assign Branch   = w_branch    & reset_n;
    assign RegWrite = w_reg_write & reset_n;
    assign MemWrite = w_mem_write & reset_n;
    assign IRWrite  = w_ir_write  & reset_n;
    assign illegal  = w_illegal   & reset_n;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed vector table, hand-written corner sequences, and a randomized run
// checked against an instruction-recipe reference model. Both ILLEGAL_TRAP settings are instantiated.
module tb_main_fsm;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_BAD = 7'b1111111;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic       mem_ready;

    logic       pc0, br0, rw0, mw0, ir0, adr0, ill0;
    logic [1:0] res0, sa0, sb0, aop0;
    logic       pc1, br1, rw1, mw1, ir1, adr1, ill1;
    logic [1:0] res1, sa1, sb1, aop1;

    // Packed view: {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal}
    logic [14:0] out0, out1;
    assign out0 = {pc0, br0, rw0, mw0, ir0, adr0, res0, sa0, sb0, aop0, ill0};
    assign out1 = {pc1, br1, rw1, mw1, ir1, adr1, res1, sa1, sb1, aop1, ill1};

    main_fsm #(.ILLEGAL_TRAP(1'b0)) u_dut_t0 (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .PCUpdate(pc0), .Branch(br0), .RegWrite(rw0), .MemWrite(mw0), .IRWrite(ir0),
        .AdrSrc(adr0), .ResultSrc(res0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0),
        .illegal(ill0)
    );

    main_fsm #(.ILLEGAL_TRAP(1'b1)) u_dut_t1 (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .PCUpdate(pc1), .Branch(br1), .RegWrite(rw1), .MemWrite(mw1), .IRWrite(ir1),
        .AdrSrc(adr1), .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1),
        .illegal(ill1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [14:0] e_fetch_r, e_fetch_w, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb, e_mwr;
    logic [14:0] e_exr, e_exi, e_jal, e_awb, e_beq, e_err;

    function automatic logic [14:0] mk(input logic pc, input logic br, input logic rw,
                                       input logic mw, input logic ir, input logic adr,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] aop,
                                       input logic ill);
        return {pc, br, rw, mw, ir, adr, res, a, b, aop, ill};
    endfunction

    task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %015b expected %015b", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic mr, input logic [6:0] o);
        @(negedge clk);
        mem_ready = mr;
        op        = o;
        #1;
    endtask

    // ---------------- reference model: each instruction is a recipe of phases ----------------
    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                      P_EXECR, P_EXECI, P_JAL, P_ALUWB, P_BEQ, P_ERR} phase_e;

    phase_e plan[8];
    int     plen;
    int     ppos;

    function automatic logic known(input logic [6:0] o);
        return o inside {T_LW, T_SW, T_R, T_I, T_JAL, T_BEQ};
    endfunction

    function automatic void m_start();
        plan[0] = P_FETCH;
        plan[1] = P_DECODE;
        plen    = 2;
        ppos    = 0;
    endfunction

    function automatic void m_push(input phase_e p);
        plan[plen] = p;
        plen++;
    endfunction

    function automatic void m_step(input logic mr, input logic [6:0] o, input logic trap);
        phase_e p;
        p = plan[ppos];
        if (p == P_ERR) return;
        if ((p == P_FETCH || p == P_MEMREAD || p == P_MEMWRITE) && !mr) return;
        if (p == P_DECODE) begin
            case (o)
                T_LW:    begin m_push(P_MEMADR); m_push(P_MEMREAD); m_push(P_MEMWB); end
                T_SW:    begin m_push(P_MEMADR); m_push(P_MEMWRITE); end
                T_R:     begin m_push(P_EXECR); m_push(P_ALUWB); end
                T_I:     begin m_push(P_EXECI); m_push(P_ALUWB); end
                T_JAL:   begin m_push(P_JAL); m_push(P_ALUWB); end
                T_BEQ:   m_push(P_BEQ);
                default: if (trap) m_push(P_ERR);
            endcase
        end
        ppos++;
        if (ppos == plen) m_start();
    endfunction

    function automatic logic [14:0] exp_of(input phase_e p, input logic mr,
                                           input logic [6:0] o, input logic trap);
        case (p)
            P_FETCH:    return mr ? e_fetch_r : e_fetch_w;
            P_DECODE:   return (!trap && !known(o)) ? e_dec_ill : e_dec;
            P_MEMADR:   return e_madr;
            P_MEMREAD:  return e_mrd;
            P_MEMWB:    return e_mwb;
            P_MEMWRITE: return e_mwr;
            P_EXECR:    return e_exr;
            P_EXECI:    return e_exi;
            P_JAL:      return e_jal;
            P_ALUWB:    return e_awb;
            P_BEQ:      return e_beq;
            default:    return e_err;
        endcase
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        rst_n;
        logic [6:0]  op;
        logic        mr;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[32];
    int   ntbl = 0;

    task automatic add(input logic r, input logic [6:0] o, input logic mr, input logic [14:0] e);
        tbl[ntbl] = '{rst_n: r, op: o, mr: mr, exp: e};
        ntbl++;
    endtask

    initial begin
        phase_e       p;
        logic         mr;
        logic [6:0]   cur_op;
        logic [6:0]   legal[6];
        logic [14:0]  e;

        reset_n   = 1'b0;
        mem_ready = 1'b0;
        op        = 7'h00;
        cur_op    = T_LW;
        legal[0] = T_LW; legal[1] = T_SW; legal[2] = T_R;
        legal[3] = T_I;  legal[4] = T_JAL; legal[5] = T_BEQ;

        e_fetch_r = mk(1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
        e_fetch_w = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
        e_dec     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
        e_dec_ill = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 1);
        e_madr    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        e_mrd     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_mwb     = mk(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        e_mwr     = mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_exr     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
        e_exi     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
        e_jal     = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
        e_awb     = mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_beq     = mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
        e_err     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);

        // reset, then lw with memory always ready (5 cycles)
        add(0, 7'h00, 1, e_fetch_w);
        add(1, 7'h55, 1, e_fetch_r);
        add(1, T_LW,  1, e_dec);
        add(1, T_LW,  1, e_madr);
        add(1, 7'h2A, 1, e_mrd);
        add(1, 7'h11, 1, e_mwb);
        // sw with three not-ready cycles in the write phase, then a stalled fetch
        add(1, 7'h00, 1, e_fetch_r);
        add(1, T_SW,  1, e_dec);
        add(1, T_SW,  1, e_madr);
        add(1, 7'h7F, 0, e_mwr);
        add(1, 7'h33, 0, e_mwr);
        add(1, 7'h01, 0, e_mwr);
        add(1, 7'h40, 1, e_mwr);
        add(1, 7'h00, 0, e_fetch_w);
        add(1, 7'h00, 1, e_fetch_r);
        // R-type then beq (3 cycles)
        add(1, T_R,   1, e_dec);
        add(1, 7'h13, 1, e_exr);
        add(1, 7'h6F, 1, e_awb);
        add(1, 7'h00, 1, e_fetch_r);
        add(1, T_BEQ, 1, e_dec);
        add(1, 7'h03, 1, e_beq);
        add(1, 7'h00, 1, e_fetch_r);

        for (int i = 0; i < ntbl; i++) begin
            @(negedge clk);
            reset_n   = tbl[i].rst_n;
            op        = tbl[i].op;
            mem_ready = tbl[i].mr;
            #1;
            chk($sformatf("vec%0d_t0", i), out0, tbl[i].exp);
            chk($sformatf("vec%0d_t1", i), out1, tbl[i].exp);
        end

        // lw interrupted by an asynchronous reset while waiting in the read phase
        cyc(1, T_LW);  chk("rst_dec", out0, e_dec);
        cyc(1, T_LW);  chk("rst_madr", out0, e_madr);
        cyc(0, 7'h00); chk("rst_mrd", out0, e_mrd);
        #2;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_async_t0", out0, e_fetch_w);
        chk("rst_async_t1", out1, e_fetch_w);
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_release_t0", out0, e_fetch_r);
        chk("rst_release_t1", out1, e_fetch_r);

        // jal: link write follows the PC update
        cyc(1, T_JAL); chk("jal_dec", out0, e_dec);
        cyc(1, 7'h00); chk("jal_jal", out0, e_jal);
        cyc(1, 7'h00); chk("jal_wb_t1", out1, e_awb);
        cyc(1, 7'h00); chk("jal_fetch", out0, e_fetch_r);

        // unknown opcode: pulse-and-continue vs. permanent trap
        cyc(1, T_BAD);
        chk("bad_dec_t0", out0, e_dec_ill);
        chk("bad_dec_t1", out1, e_dec);
        for (int k = 0; k < 10; k++) begin
            cyc(0, T_BAD);
            chk($sformatf("bad_hold%0d_t0", k), out0, e_fetch_w);
            chk($sformatf("bad_hold%0d_t1", k), out1, e_err);
        end
        cyc(1, T_BAD);
        chk("bad_f_t0", out0, e_fetch_r);
        chk("bad_f_t1", out1, e_err);
        cyc(1, T_BAD);
        chk("bad_dec2_t0", out0, e_dec_ill);
        chk("bad_dec2_t1", out1, e_err);
        cyc(1, T_LW);
        chk("bad_back_t0", out0, e_fetch_r);
        chk("bad_stuck_t1", out1, e_err);

        // randomized legal instruction stream with random stalls and occasional resets
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rnd_rst_t0", out0, e_fetch_w);
        chk("rnd_rst_t1", out1, e_fetch_w);
        m_start();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            mr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) begin
                reset_n   = 1'b0;
                mem_ready = mr;
                op        = 7'($urandom);
                #1;
                chk($sformatf("rnd%0d_rst_t0", c), out0, e_fetch_w);
                chk($sformatf("rnd%0d_rst_t1", c), out1, e_fetch_w);
                m_start();
                continue;
            end
            reset_n = 1'b1;
            p = plan[ppos];
            if (p == P_DECODE) cur_op = legal[$urandom_range(0, 5)];
            op        = (p == P_DECODE || p == P_MEMADR) ? cur_op : 7'($urandom);
            mem_ready = mr;
            #1;
            e = exp_of(p, mr, op, 1'b0);
            chk($sformatf("rnd%0d_t0", c), out0, e);
            chk($sformatf("rnd%0d_t1", c), out1, e);
            m_step(mr, op, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
